// File: rtl/subtractor_pkg.sv
// -----------------------------------------------------------------------------
// subtractor_pkg
// Shared definitions for the bit-serial subtractor:
//   - FSM state encoding (ST_IDLE / ST_RUN / ST_DONE; code 2'd3 falls back to idle)
//   - typed state enum built on that encoding
//   - signed-overflow helper applied to the final result bit
// Bit-cell reference (implemented structurally in full_subtractor):
//   diff = a ^ b ^ bin
//   bout = (~a & b) | (~(a ^ b) & bin)
// -----------------------------------------------------------------------------
package subtractor_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StRun  = ST_RUN,
        StDone = ST_DONE
    } state_e;

    // Two's complement overflow of a - b: operands differ in sign and the
    // result sign differs from the minuend sign.
    function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                          input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// Purely combinational 1-bit full subtractor built from two half-subtractor
// stages plus an OR of their borrows.
// Ports:
//   a    in   minuend bit
//   b    in   subtrahend bit
//   bin  in   incoming borrow
//   diff out  a - b - bin (difference bit)
//   bout out  outgoing borrow
// -----------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic hs1_diff;
    logic hs1_bout;
    logic hs2_bout;

    // First half subtractor: a - b
    assign hs1_diff = a ^ b;
    assign hs1_bout = ~a & b;

    // Second half subtractor: (a - b) - bin
    assign diff     = hs1_diff ^ bin;
    assign hs2_bout = ~hs1_diff & bin;

    assign bout     = hs1_bout | hs2_bout;

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor: diff = a - b - borrow_in over WIDTH bits, one bit per
// clock through a single full_subtractor cell, with a start/busy/done handshake.
// Multi-word chains connect borrow_out of the lower word to borrow_in of the
// next.
// Parameters:
//   WIDTH       operand/result width (>= 2)
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       request, sampled only in idle
//   a, b        minuend / subtrahend, captured on accepted start
//   borrow_in   initial borrow, captured on accepted start
//   busy        high while bits are being processed
//   done        one-cycle pulse when results become valid
//   diff        result, held until the next accepted start
//   borrow_out  final borrow (1 = unsigned a < b + borrow_in)
//   overflow    signed overflow of a - b - borrow_in
// -----------------------------------------------------------------------------
module serial_subtractor
    import subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             br_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic [CW-1:0]    cnt_q;

    logic cell_diff;
    logic cell_bout;

    full_subtractor u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            br_q       <= 1'b0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            cnt_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= borrow_in;
                        // Operand sign bits are kept aside; the shift registers
                        // lose them as bits are consumed.
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end
                end

                StRun: begin
                    // LSB first in, so after WIDTH shifts bit 0 sits at diff[0].
                    diff  <= {cell_diff, diff[WIDTH-1:1]};
                    a_q   <= {1'b0, a_q[WIDTH-1:1]};
                    b_q   <= {1'b0, b_q[WIDTH-1:1]};
                    br_q  <= cell_bout;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        borrow_out <= cell_bout;
                        overflow   <= sub_overflow(a_msb_q, b_msb_q, cell_diff);
                        state_q    <= StDone;
                    end
                end

                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor (WIDTH=8). An arithmetic model
// predicts busy/done timing and results; a compare process checks the DUT on
// every falling edge, and directed operations pin literal expected values.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         borrow_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;

    int n_vec = 0;
    int n_fail = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference result {overflow, borrow, diff} from plain integer arithmetic.
    function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic bi);
        logic [W:0] u;
        longint     s;
        longint     lim;
        logic       ov;
        u   = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
        s   = longint'($signed(x)) - longint'($signed(y)) - longint'(bi);
        lim = longint'(1) << (W - 1);
        ov  = (s > lim - 1) || (s < -lim);
        return {ov, u[W], u[W-1:0]};
    endfunction

    // Timeline model: t counts edges since the accepting edge, -1 when idle.
    int           t = -1;
    logic [W-1:0] ea, eb;
    logic         ebin;
    logic         m_busy = 1'b0, m_done = 1'b0, m_bo = 1'b0, m_ov = 1'b0, m_run = 1'b0;
    logic [W-1:0] m_diff = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = -1; m_busy = 0; m_done = 0; m_bo = 0; m_ov = 0; m_run = 0; m_diff = '0;
        end else if (t < 0) begin
            if (start) begin
                ea = a; eb = b; ebin = borrow_in;
                t = 0; m_busy = 1; m_run = 1;
            end
        end else begin
            t++;
            if (t == W) begin
                {m_ov, m_bo, m_diff} = ref_sub(ea, eb, ebin);
                m_busy = 0; m_done = 1; m_run = 0;
            end else if (t == W + 1) begin
                m_done = 0; t = -1;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("borrow_out", borrow_out, m_bo);
        chk("overflow", overflow, m_ov);
        // diff carries partial shift contents while an operation is running.
        if (!m_run) chk("diff", diff, m_diff);
    end

    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                         input logic [W-1:0] ed, input logic ebo, input logic eov,
                         input string tag);
        int   n;
        int   nbusy;
        logic seen;
        repeat (2) @(negedge clk);
        a = xa; b = xb; borrow_in = xbin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Post-capture operand changes must not matter.
        a = ~xa; b = ~xb; borrow_in = ~xbin;
        nbusy = busy ? 1 : 0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < W + 4) begin
            @(posedge clk); #1;
            n++;
            if (done) seen = 1'b1;
            else if (busy) nbusy++;
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_latency"}, n + 1, W + 1);
        chk({tag, "_busy_cycles"}, nbusy, W);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_borrow"}, borrow_out, ebo);
        chk({tag, "_ovf"}, overflow, eov);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        int   last;
        int   ndone;
        logic seen;
        logic [W+1:0] r;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow_out, 0);
        chk("rst_ovf", overflow, 0);
        rst_n = 1'b1;

        // Pin the model against hand-computed values
        chk("model_a", ref_sub(8'h05, 8'h03, 1'b0), {2'b00, 8'h02});
        chk("model_b", ref_sub(8'h80, 8'h01, 1'b0), {2'b10, 8'h7F});
        chk("model_c", ref_sub(8'h7F, 8'hFF, 1'b0), {2'b11, 8'h80});

        // Directed operations
        do_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "t1");
        do_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, "t2a");
        do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "t2b");
        do_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "t3a");
        do_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "t3b");

        // Start held high with operands changing every cycle
        @(negedge clk);
        start = 1'b1;
        last = -1;
        ndone = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done) begin
                if (last >= 0) chk("t4_spacing", i - last, W + 2);
                last = i;
                ndone++;
            end
            a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
        end
        chk("t4_ops", (ndone >= 4), 1);
        start = 1'b0;
        repeat (2 * W + 4) @(negedge clk);

        // Reset in the middle of an operation
        @(negedge clk);
        a = 8'h55; b = 8'h11; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_diff", diff, 0);
        chk("t5_borrow", borrow_out, 0);
        chk("t5_ovf", overflow, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("t5_no_done", seen, 0);
        do_op(8'h10, 8'h20, 1'b1, 8'hEF, 1'b1, 1'b0, "t5_after");

        // Random operations, expectations from the arithmetic reference
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra, rb;
            logic         rbi;
            ra = W'($urandom); rb = W'($urandom); rbi = 1'($urandom);
            r = ref_sub(ra, rb, rbi);
            do_op(ra, rb, rbi, r[W-1:0], r[W], r[W+1], "rnd");
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
